// File: rtl/cr_cart_loader.sv
// rtl/cr_cart_loader.sv - cartridge image store, loader FSM and console read/write port
//
// Captures a ROM image from the HPS download port into a 2^ADDR_W byte memory,
// tracks the highest byte offset written (rom_size), and serves the console's
// cart reads once the image is loaded. The console is held in reset from the
// start of a download until HOLD_CYCLES cycles after it ends.
//
// Optional feature: define CART_RAM_EN to let the console write the memory in
// RUN through cart_write/cart_dout. Without it the memory is read-only outside
// CLEAR/LOAD and cart_write/cart_dout are ignored.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   dl_active          download in progress (level)
//   dl_wr              one-cycle byte strobe
//   dl_addr, dl_data   byte offset and data of a download write
//   dl_wait            high while the memory is being cleared; no dl_wr allowed
//   rom_addr           console cart address (upper bits ignored, window wraps)
//   rom_do             read data, 1-cycle latency, 0xFF outside RUN
//   cart_dout          console write data
//   cart_write         console write strobes (bit 1 ROM2, bit 0 ROM1)
//   rom_size           highest accepted download offset (image size minus 1)
//   hold_reset         console reset request (CLEAR, LOAD, HOLD)
//   dl_err             sticky protocol error flag, cleared on CLEAR entry

module cr_cart_loader #(
  parameter int ADDR_W      = 15,
  parameter int HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [15:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  input  logic [15:0] rom_addr,
  output logic [7:0]  rom_do,
  input  logic [7:0]  cart_dout,
  input  logic [1:0]  cart_write,
  output logic [15:0] rom_size,
  output logic        hold_reset,
  output logic        dl_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_HOLD,
    S_RUN
  } state_t;

  localparam int          HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [16:0] MEM_BYTES = 17'(1) << ADDR_W;

  state_t              state;
  state_t              state_next;
  logic                dl_active_q;
  logic                dl_rise;
  logic                dl_fall;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                hold_done;
  logic                addr_ok;
  logic                wr_accept;
  logic                wr_reject;
  logic                clear_entry;

  logic [7:0]          mem [0:(2**ADDR_W)-1];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [7:0]          mem_wdata;

  // Sink for inputs that are not used in every build configuration.
  logic                unused_inputs;
  assign unused_inputs = ^{rom_addr, cart_dout, cart_write};

  assign dl_rise     = dl_active & ~dl_active_q;
  assign dl_fall     = ~dl_active & dl_active_q;
  assign hold_done   = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
  assign addr_ok     = ({1'b0, dl_addr} < MEM_BYTES);
  assign wr_accept   = (state == S_LOAD) & dl_wr & addr_ok;
  // Anything not accepted is a protocol error: wrong state or out-of-range.
  assign wr_reject   = dl_wr & ~wr_accept;
  assign clear_entry = (state_next == S_CLEAR) & (state != S_CLEAR);

  always_comb begin
    state_next = state;
    dl_wait    = 1'b0;
    hold_reset = 1'b0;
    case (state)
      S_IDLE: begin
        if (dl_rise) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        dl_wait    = 1'b1;
        hold_reset = 1'b1;
        if (clr_cnt == '1) state_next = S_LOAD;
      end
      S_LOAD: begin
        hold_reset = 1'b1;
        // A dl_wr in the falling-edge cycle is still accepted since state is LOAD.
        if (dl_fall) state_next = S_HOLD;
      end
      S_HOLD: begin
        hold_reset = 1'b1;
        if (hold_done) state_next = S_RUN;
      end
      S_RUN: begin
        if (dl_rise) state_next = S_CLEAR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // Sampled through reset so a level held high across reset is not seen as a new rise.
    dl_active_q <= dl_active;
    if (reset) begin
      state    <= S_IDLE;
      clr_cnt  <= '0;
      hold_cnt <= '0;
      rom_size <= 16'h0000;
      dl_err   <= 1'b0;
      rom_do   <= 8'hFF;
    end else begin
      state <= state_next;

      if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      else                  clr_cnt <= '0;

      if (state == S_HOLD) hold_cnt <= hold_cnt + 1'b1;
      else                 hold_cnt <= '0;

      if (clear_entry)                          rom_size <= 16'h0000;
      else if (wr_accept && dl_addr > rom_size) rom_size <= dl_addr;

      if (clear_entry)    dl_err <= 1'b0;
      else if (wr_reject) dl_err <= 1'b1;

      rom_do <= (state == S_RUN) ? mem[rom_addr[ADDR_W-1:0]] : 8'hFF;
    end
  end

  // Single write port shared by clear, download and (optionally) console.
  // The states are mutually exclusive, so the mux never has to arbitrate.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = dl_addr[ADDR_W-1:0];
    mem_wdata = dl_data;
    case (state)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        mem_wdata = 8'hFF;
      end
      S_LOAD: begin
        mem_we = wr_accept;
      end
`ifdef CART_RAM_EN
      S_RUN: begin
        mem_we    = |cart_write;
        mem_waddr = rom_addr[ADDR_W-1:0];
        mem_wdata = cart_dout;
      end
`endif
      default: ;
    endcase
    // Reset aborts a clear or load without touching memory in that cycle.
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule
